multi_lane_impairment_channel: RTL and testbench

- Parametrised successor to the single-lane jitter/BER channel; models a LANES-wide serial link for the PHY UVM environment.
- Each lane gets, in order:
  1. programmable inter-lane skew (delay in valid beats),
  2. polarity inversion,
  3. deterministic LFSR-driven bit-error injection, with burst and one-shot forced-error modes.
- Maintains per-lane saturating error counters.
- Fully synthesizable and reproducible from SEED, so scoreboards can predict every flipped bit.

---
 rtl/multi_lane_impairment_channel_if.sv | 36 +++
 rtl/multi_lane_impairment_channel.sv | 112 +++++++++++
 tb/tb_multi_lane_impairment_channel.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_lane_impairment_channel_if.sv
// Bundle of data, configuration and status signals for the multi-lane
// impairment channel. The master side drives stimulus/config, the slave
// side is the channel itself.
interface multi_lane_impairment_channel_if #(
   parameter int LANES   = 4,
   parameter int SKEW_W  = 3,
   parameter int BURST_W = 4,
   parameter int CNT_W   = 16
);
   logic [LANES-1:0]        serial_in;
   logic                    in_valid;
   logic                    enable_ber;
   logic [15:0]             ber_thresh;
   logic [BURST_W-1:0]      burst_len;
   logic [LANES*SKEW_W-1:0] lane_skew;
   logic [LANES-1:0]        invert_mask;
   logic [LANES-1:0]        inject_err;
   logic                    clr_cnt;

   logic [LANES-1:0]        serial_out;
   logic                    out_valid;
   logic [LANES-1:0]        err_flag;
   logic [LANES*CNT_W-1:0]  err_count;

   modport master (
      output serial_in, in_valid, enable_ber, ber_thresh, burst_len,
             lane_skew, invert_mask, inject_err, clr_cnt,
      input  serial_out, out_valid, err_flag, err_count
   );

   modport slave (
      input  serial_in, in_valid, enable_ber, ber_thresh, burst_len,
             lane_skew, invert_mask, inject_err, clr_cnt,
      output serial_out, out_valid, err_flag, err_count
   );
endinterface

// File: rtl/multi_lane_impairment_channel.sv
// Multi-lane serial impairment channel: per-lane skew (in valid beats),
// polarity inversion and reproducible LFSR-driven bit-error injection with
// burst and forced one-shot modes, plus saturating per-lane error counters.
module multi_lane_impairment_channel #(
   parameter int          LANES    = 4,
   parameter int          MAX_SKEW = 7,
   parameter int          SKEW_W   = 3,
   parameter int          BURST_W  = 4,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] SEED     = 32'h1ACE_B00C
) (
   input  logic clk,
   input  logic rst,
   multi_lane_impairment_channel_if.slave bus
);
   localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
   localparam logic [31:0]      LANE_MIX  = 32'h9E37_79B9;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [MAX_SKEW-1:0] r_hist  [LANES];
   logic [31:0]         r_lfsr  [LANES];
   logic [BURST_W-1:0]  r_burst [LANES];
   logic [CNT_W-1:0]    r_cnt   [LANES];
   logic [LANES-1:0]    r_pend;
   logic [LANES-1:0]    r_out;
   logic [LANES-1:0]    r_flag;
   logic                r_valid;

   logic [MAX_SKEW:0]   w_ext   [LANES];
   logic [LANES-1:0]    w_data;
   logic [LANES-1:0]    w_hit;
   logic [LANES-1:0]    w_flip;

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
   endfunction

   // Each lane starts from a distinct, never-zero state derived from SEED.
   function automatic logic [31:0] lfsr_seed(input int lane);
      logic [31:0] s;
      s = SEED ^ (32'(lane) * LANE_MIX);
      return (s == '0) ? 32'd1 : s;
   endfunction

   // Per-lane skew select (oversized skew falls through to MAX_SKEW) and flip decision.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_ext[l]  = {r_hist[l], bus.serial_in[l]};
         w_data[l] = w_ext[l][MAX_SKEW];
         for (int k = 0; k < MAX_SKEW; k++) begin
            if (bus.lane_skew[l*SKEW_W +: SKEW_W] == SKEW_W'(k)) w_data[l] = w_ext[l][k];
         end
         w_hit[l]  = bus.enable_ber && (r_lfsr[l][15:0] < bus.ber_thresh);
         // Any combination of burst, random and forced sources yields one flip.
         w_flip[l] = (r_burst[l] != '0) | w_hit[l] | r_pend[l] | bus.inject_err[l];
      end
   end

   // Registered outputs plus history, LFSR, burst and pending-force state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_out   <= '0;
         r_flag  <= '0;
         r_pend  <= '0;
         for (int l = 0; l < LANES; l++) begin
            r_hist[l]  <= '0;
            r_lfsr[l]  <= lfsr_seed(l);
            r_burst[l] <= '0;
         end
      end else begin
         r_valid <= bus.in_valid;
         r_flag  <= '0;
         for (int l = 0; l < LANES; l++) begin
            if (bus.in_valid) begin
               r_out[l]  <= w_data[l] ^ bus.invert_mask[l] ^ w_flip[l];
               r_flag[l] <= w_flip[l];
               r_hist[l] <= w_ext[l][MAX_SKEW-1:0];
               r_lfsr[l] <= lfsr_next(r_lfsr[l]);
               r_pend[l] <= 1'b0;
               if (r_burst[l] != '0) r_burst[l] <= r_burst[l] - BURST_W'(1);
               else if (w_hit[l])    r_burst[l] <= bus.burst_len;
            end else begin
               r_pend[l] <= r_pend[l] | bus.inject_err[l];
            end
         end
      end
   end

   // Saturating error counters; a clear still records a flip on the same beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < LANES; l++) r_cnt[l] <= '0;
      end else begin
         for (int l = 0; l < LANES; l++) begin
            if (bus.clr_cnt)
               r_cnt[l] <= CNT_W'(bus.in_valid & w_flip[l]);
            else if (bus.in_valid && w_flip[l] && (r_cnt[l] != CNT_MAX))
               r_cnt[l] <= r_cnt[l] + CNT_W'(1);
         end
      end
   end

   // Drive the bus from registered state only.
   always_comb begin
      bus.serial_out = r_out;
      bus.out_valid  = r_valid;
      bus.err_flag   = r_flag;
      bus.err_count  = '0;
      for (int l = 0; l < LANES; l++) bus.err_count[l*CNT_W +: CNT_W] = r_cnt[l];
   end
endmodule

// File: tb/tb_multi_lane_impairment_channel.sv
// Scoreboard bench for multi_lane_impairment_channel: a beat-level reference
// model predicts every output cycle; a monitor compares on the falling edge.
// A second instance with 4-bit counters shares the stimulus to show saturation.
module tb_multi_lane_impairment_channel;
   localparam int          LANES    = 4;
   localparam int          MAX_SKEW = 7;
   localparam int          SKEW_W   = 4;
   localparam int          BURST_W  = 4;
   localparam int          CNT_W    = 16;
   localparam int          SAT_W    = 4;
   localparam logic [31:0] SEED     = 32'h1ACE_B00C;

   typedef struct packed {
      logic [31:0]         due;
      logic                valid;
      logic [LANES-1:0]    out;
      logic [LANES-1:0]    flag;
      logic [LANES*32-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multi_lane_impairment_channel_if #(.LANES(LANES), .SKEW_W(SKEW_W), .BURST_W(BURST_W), .CNT_W(CNT_W)) ifm ();
   multi_lane_impairment_channel_if #(.LANES(LANES), .SKEW_W(SKEW_W), .BURST_W(BURST_W), .CNT_W(SAT_W)) ifs ();

   assign ifs.serial_in   = ifm.serial_in;
   assign ifs.in_valid    = ifm.in_valid;
   assign ifs.enable_ber  = ifm.enable_ber;
   assign ifs.ber_thresh  = ifm.ber_thresh;
   assign ifs.burst_len   = ifm.burst_len;
   assign ifs.lane_skew   = ifm.lane_skew;
   assign ifs.invert_mask = ifm.invert_mask;
   assign ifs.inject_err  = ifm.inject_err;
   assign ifs.clr_cnt     = ifm.clr_cnt;

   multi_lane_impairment_channel #(.LANES(LANES), .MAX_SKEW(MAX_SKEW), .SKEW_W(SKEW_W),
      .BURST_W(BURST_W), .CNT_W(CNT_W), .SEED(SEED)) u_dut (.clk(clk), .rst(rst), .bus(ifm));

   multi_lane_impairment_channel #(.LANES(LANES), .MAX_SKEW(MAX_SKEW), .SKEW_W(SKEW_W),
      .BURST_W(BURST_W), .CNT_W(SAT_W), .SEED(SEED)) u_sat (.clk(clk), .rst(rst), .bus(ifs));

   // configuration currently applied
   logic                    cfg_en;
   logic [15:0]             cfg_thresh;
   logic [BURST_W-1:0]      cfg_burst;
   logic [LANES*SKEW_W-1:0] cfg_skew;
   logic [LANES-1:0]        cfg_inv;

   // reference model state
   logic [31:0]      m_lfsr [LANES];
   int               m_brem [LANES];
   bit               m_pend [LANES];
   int               m_cnt  [LANES];
   bit               m_hist [LANES][$];
   logic [LANES-1:0] m_out;

   exp_t q[$];
   exp_t me;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic longint sat(input int c, input int w);
      longint top;
      top = (longint'(1) << w) - 1;
      return (c > top) ? top : longint'(c);
   endfunction

   task automatic model_reset();
      for (int l = 0; l < LANES; l++) begin
         m_lfsr[l] = SEED ^ (32'(l) * 32'h9E37_79B9);
         if (m_lfsr[l] == 0) m_lfsr[l] = 1;
         m_brem[l] = 0;
         m_pend[l] = 0;
         m_cnt[l]  = 0;
         m_hist[l].delete();
         for (int k = 0; k < MAX_SKEW; k++) m_hist[l].push_back(1'b0);
      end
      m_out = '0;
   endtask

   // One clock of stimulus; the model predicts what the DUT shows one clock later.
   task automatic step(input bit v, input logic [LANES-1:0] d, input logic [LANES-1:0] inj,
                       input bit clr, input bit r);
      exp_t x;
      int   sk;
      bit   dd, hit, fl;
      @(posedge clk);
      #1;
      rst             = r;
      ifm.in_valid    = v;
      ifm.serial_in   = d;
      ifm.inject_err  = inj;
      ifm.clr_cnt     = clr;
      ifm.enable_ber  = cfg_en;
      ifm.ber_thresh  = cfg_thresh;
      ifm.burst_len   = cfg_burst;
      ifm.lane_skew   = cfg_skew;
      ifm.invert_mask = cfg_inv;
      x     = '0;
      x.due = cyc + 1;
      if (r) begin
         model_reset();
      end else begin
         for (int l = 0; l < LANES; l++) begin
            fl = 0;
            m_pend[l] |= inj[l];
            if (v) begin
               sk = int'(cfg_skew[l*SKEW_W +: SKEW_W]);
               if (sk > MAX_SKEW) sk = MAX_SKEW;
               dd  = (sk == 0) ? d[l] : m_hist[l][m_hist[l].size() - sk];
               hit = cfg_en && (m_lfsr[l][15:0] < cfg_thresh);
               if (m_brem[l] > 0) begin
                  fl = 1;
                  m_brem[l]--;
               end else if (hit) begin
                  fl = 1;
                  m_brem[l] = int'(cfg_burst);
               end
               if (m_pend[l]) fl = 1;
               m_pend[l] = 0;
               m_lfsr[l] = lfsr_step(m_lfsr[l]);
               m_hist[l].push_back(d[l]);
               void'(m_hist[l].pop_front());
               m_out[l]  = dd ^ cfg_inv[l] ^ fl;
               x.flag[l] = fl;
            end
            if (clr) m_cnt[l] = int'(fl);
            else     m_cnt[l] += int'(fl);
         end
         x.valid = v;
      end
      x.out = m_out;
      for (int l = 0; l < LANES; l++) x.cnt[l*32 +: 32] = m_cnt[l];
      q.push_back(x);
   endtask

   // Monitor: compares every predicted cycle when it falls due.
   always @(negedge clk) begin
      logic [LANES*CNT_W-1:0] xm;
      logic [LANES*SAT_W-1:0] xs;
      while (q.size() != 0 && q[0].due <= cyc) begin
         me = q.pop_front();
         for (int l = 0; l < LANES; l++) begin
            xm[l*CNT_W +: CNT_W] = CNT_W'(sat(int'(me.cnt[l*32 +: 32]), CNT_W));
            xs[l*SAT_W +: SAT_W] = SAT_W'(sat(int'(me.cnt[l*32 +: 32]), SAT_W));
         end
         chk("beat_slot",  64'(cyc),            64'(me.due));
         chk("out_valid",  64'(ifm.out_valid),  64'(me.valid));
         chk("serial_out", 64'(ifm.serial_out), 64'(me.out));
         chk("err_flag",   64'(ifm.err_flag),   64'(me.flag));
         chk("err_count",  64'(ifm.err_count),  64'(xm));
         chk("sat_count",  64'(ifs.err_count),  64'(xs));
      end
   end

   logic [6:0] prbs;
   logic [7:0] pat;

   function automatic logic [LANES-1:0] rnd_lanes();
      return LANES'($urandom);
   endfunction

   initial begin
      logic [LANES-1:0] d;
      bit               b;
      cfg_en = 0; cfg_thresh = '0; cfg_burst = '0; cfg_skew = '0; cfg_inv = '0;
      ifm.serial_in = '0; ifm.in_valid = 0; ifm.enable_ber = 0; ifm.ber_thresh = '0;
      ifm.burst_len = '0; ifm.lane_skew = '0; ifm.invert_mask = '0; ifm.inject_err = '0;
      ifm.clr_cnt = 0;
      model_reset();

      // reset for two clocks
      step(0, '0, '0, 0, 1);
      step(0, '0, '0, 0, 1);

      // transparent path, lane0 pattern 1011_0010 then gaps
      pat = 8'b1011_0010;
      for (int i = 7; i >= 0; i--) begin
         d = rnd_lanes(); d[0] = pat[i];
         step(1, d, '0, 0, 0);
      end
      repeat (3) step(0, rnd_lanes(), '0, 0, 0);
      repeat (12) step($urandom_range(0, 1) == 1, rnd_lanes(), '0, 0, 0);

      // skew {3,0,7,2} lane3..0, lane2 inverted, PRBS7 on all lanes
      cfg_skew = {4'd3, 4'd0, 4'd7, 4'd2};
      cfg_inv  = 4'b0100;
      prbs = 7'h7F;
      for (int i = 0; i < 80; i++) begin
         b    = prbs[6] ^ prbs[5];
         prbs = {prbs[5:0], b};
         if (i == 50) cfg_skew = {4'd15, 4'd0, 4'd7, 4'd9};
         step($urandom_range(0, 4) != 0, {LANES{b}}, '0, 0, 0);
      end

      // deterministic BER from a fresh seed, then zero threshold
      cfg_skew = '0; cfg_inv = '0;
      step(0, '0, '0, 0, 1);
      cfg_en = 1; cfg_thresh = 16'hFFFF; cfg_burst = '0;
      repeat (1000) step(1, rnd_lanes(), '0, 0, 0);
      cfg_thresh = 16'h0000;
      repeat (50) step(1, rnd_lanes(), '0, 0, 0);

      // bursts of 1+3 flips
      cfg_thresh = 16'h0800; cfg_burst = 4'd3;
      repeat (600) step($urandom_range(0, 4) != 0, rnd_lanes(), '0, 0, 0);

      // forced error: two pulses while idle give one flip
      cfg_en = 0; cfg_burst = '0;
      repeat (4) step(0, '0, '0, 0, 0);
      step(0, '0, '0, 1, 0);
      step(0, '0, 4'b0100, 0, 0);
      step(0, '0, '0, 0, 0);
      step(0, '0, 4'b0100, 0, 0);
      step(1, rnd_lanes(), '0, 0, 0);
      repeat (3) step(1, rnd_lanes(), '0, 0, 0);
      step(1, rnd_lanes(), 4'b1001, 0, 0);

      // saturation of the 4-bit counters, then clear on a flip beat
      cfg_en = 1; cfg_thresh = 16'hFFFF;
      repeat (40) step(1, rnd_lanes(), '0, 0, 0);
      step(1, rnd_lanes(), '0, 1, 0);
      step(1, rnd_lanes(), '0, 0, 0);

      // reset in the middle of a burst, then the sequence restarts
      cfg_thresh = 16'hFFFF; cfg_burst = 4'd5;
      step(0, '0, '0, 0, 1);
      repeat (4) step(1, rnd_lanes(), '0, 0, 0);
      step(1, rnd_lanes(), '0, 0, 1);
      cfg_en = 0;
      repeat (5) step(1, rnd_lanes(), '0, 0, 0);
      cfg_en = 1; cfg_burst = '0;
      repeat (20) step(1, rnd_lanes(), '0, 0, 0);

      // randomized mix of everything
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) begin
            cfg_en     = $urandom_range(0, 1) == 1;
            cfg_thresh = 16'($urandom_range(0, 16'h3000));
            cfg_burst  = BURST_W'($urandom);
            cfg_skew   = (LANES*SKEW_W)'($urandom);
            cfg_inv    = rnd_lanes();
         end
         step($urandom_range(0, 3) != 0, rnd_lanes(),
              ($urandom_range(0, 9) == 0) ? rnd_lanes() : '0,
              $urandom_range(0, 49) == 0, 0);
      end

      repeat (3) step(0, '0, '0, 0, 0);
      repeat (4) @(negedge clk);
      chk("drain_empty", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
